// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_pkg                                                                   |
// | Shared types and elaboration helpers for the convolution datapath blocks.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } agen_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int out_dim(input int img, input int k, input int stride, input int pad);
        return (img + 2 * pad - k) / stride + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_wrap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_wrap_counter                                                          |
// | Modulo-(MAX+1) counter with clear; wrap flags the increment from MAX.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module conv_wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic [W-1:0] r_value;

    assign wrap  = inc && (r_value == W'(MAX));
    assign value = r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= wrap ? '0 : r_value + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_agen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_window_agen                                                           |
// | Sliding-window tap address generator with valid/ready output.              |
// | Define CONV_AGEN_PAD_EN for "same" zero-padding (adds the pad port).       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module conv_window_agen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 4,
    localparam int TAP_W = width_of(K * K)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [TAP_W-1:0]  tap,
    output logic              win_first,
    output logic              win_last,
    output logic              frame_last,
    output logic              busy,
`ifdef CONV_AGEN_PAD_EN
    output logic              pad,
`endif
    output logic              done
);

`ifdef CONV_AGEN_PAD_EN
    localparam int c_pad = (K - 1) / 2;
`else
    localparam int c_pad = 0;
`endif
    localparam int c_out_w = out_dim(IMG_W, K, STRIDE, c_pad);
    localparam int c_out_h = out_dim(IMG_H, K, STRIDE, c_pad);
    localparam int c_kw    = width_of(K);
    localparam int c_ow    = width_of(c_out_w);
    localparam int c_oh    = width_of(c_out_h);

    agen_state_t r_state, w_state_nxt;
    logic            w_clr, w_xfer, w_run;
    logic [c_kw-1:0] w_kc, w_kr;
    logic [c_ow-1:0] w_ocol;
    logic [c_oh-1:0] w_orow;
    logic            w_wrap_kc, w_wrap_kr, w_wrap_ocol, w_wrap_orow;
    logic            w_tap_last, w_out;
    int              w_row, w_col, w_lin;

    assign w_run  = (r_state == RUN);
    assign w_xfer = w_run && addr_ready;

    // Cascade: each stage steps only when every inner stage wraps on a transfer.
    conv_wrap_counter #(.MAX(K - 1), .W(c_kw)) u_kc (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(w_xfer),
        .value(w_kc), .wrap(w_wrap_kc));
    conv_wrap_counter #(.MAX(K - 1), .W(c_kw)) u_kr (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(w_wrap_kc),
        .value(w_kr), .wrap(w_wrap_kr));
    conv_wrap_counter #(.MAX(c_out_w - 1), .W(c_ow)) u_ocol (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(w_wrap_kr),
        .value(w_ocol), .wrap(w_wrap_ocol));
    conv_wrap_counter #(.MAX(c_out_h - 1), .W(c_oh)) u_orow (
        .clk(clk), .rst(reset), .clr(w_clr), .inc(w_wrap_ocol),
        .value(w_orow), .wrap(w_wrap_orow));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clr       = 1'b1;
                end
            end
            RUN:     if (w_wrap_orow) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Only constant multiplies; padding shifts the window origin by -P.
    always_comb begin
        w_row = int'(w_orow) * STRIDE + int'(w_kr) - c_pad;
        w_col = int'(w_ocol) * STRIDE + int'(w_kc) - c_pad;
`ifdef CONV_AGEN_PAD_EN
        w_out = (w_row < 0) || (w_row >= IMG_H) || (w_col < 0) || (w_col >= IMG_W);
`else
        w_out = 1'b0;
`endif
        w_lin = w_out ? 0 : (w_row * IMG_W + w_col);
    end

    assign w_tap_last = (w_kr == c_kw'(K - 1)) && (w_kc == c_kw'(K - 1));

    assign addr_valid = w_run;
    assign busy       = w_run;
    assign done       = (r_state == FIN);
    assign addr       = ADDR_W'(w_lin);
    assign tap        = TAP_W'(int'(w_kr) * K + int'(w_kc));
    assign win_first  = w_run && (w_kr == '0) && (w_kc == '0);
    assign win_last   = w_run && w_tap_last;
    assign frame_last = w_run && w_tap_last
                        && (w_ocol == c_ow'(c_out_w - 1))
                        && (w_orow == c_oh'(c_out_h - 1));
`ifdef CONV_AGEN_PAD_EN
    assign pad        = w_run && w_out;
`endif

endmodule
`default_nettype wire

// File: doc/conv_window_agen.md
# conv_window_agen

Parametrised sliding-window address generator for the convolution datapath. It generates image-memory read addresses for every kernel tap of every output window, in raster order. It replaces the fixed 4x4/3x3 hard-wired tap counter and adds configurable image size, kernel size and stride, a valid/ready output handshake, window/frame markers, and optional zero-padding. It sits between the convolution controller (START/DONE) and the pixel memory read port.

## Interface
- IMG_W, 4, image width in pixels (≥ K)
- IMG_H, 4, image height in pixels (≥ K)
- K, 3, kernel side length (odd, ≥ 1)
- STRIDE, 1, window step in both directions (≥ 1)
- ADDR_W, 4, address width; must be ≥ clog2(IMG_W*IMG_H)
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  begin a frame; sampled only in IDLE
- ADDR_READY  in  1  consumer accepts the current address
- ADDR_VALID  out  1  ADDR/TAP/flags are valid
- ADDR  out  ADDR_W  pixel address = row*IMG_W + col
- TAP  out  clog2(K*K)  kernel tap index = kr*K + kc
- WIN_FIRST  out  1  TAP == 0
- WIN_LAST  out  1  TAP == K*K-1
- FRAME_LAST  out  1  last tap of last window
- BUSY  out  1  state is RUN
- DONE  out  1  one-cycle pulse after the frame completes
- PAD  out  1  tap lies outside the image (only with CONV_AGEN_PAD_EN)

## Operation
- FSM states: IDLE → RUN (START=1) → FIN (transfer with FRAME_LAST) → IDLE, unconditionally after one cycle.
- Four counters in cascade: kc (0..K-1), kr (0..K-1), ocol (0..OUT_W-1), orow (0..OUT_H-1). Each counter advances on a transfer (ADDR_VALID & ADDR_READY) when all inner counters wrap.
- Without padding:
  - OUT_W = (IMG_W-K)/STRIDE+1 and OUT_H = (IMG_H-K)/STRIDE+1 (integer division).
  - row = orow*STRIDE+kr; col = ocol*STRIDE+kc.
- Address multiplies are by constants only; no runtime multiplier.
- START while in RUN or FIN is ignored.
- ADDR_READY outside RUN is ignored.
- All counters are cleared on entry to RUN.
- Reset values: state IDLE, all counters 0, ADDR_VALID/BUSY/DONE/WIN_*/FRAME_LAST/PAD = 0, ADDR = 0, TAP = 0.
- Reset asserted mid-frame aborts immediately. No DONE pulse is produced. The next START restarts from window 0, tap 0.

## Timing
- START high in IDLE at edge n: ADDR_VALID=1 from cycle n+1, presenting tap 0 of window 0.
- Outputs are driven from registered state. While ADDR_VALID & !ADDR_READY, ADDR/TAP/flags must hold stable.
- One address per cycle with ADDR_READY held high. A frame takes OUT_W*OUT_H*K*K cycles with no gaps, including across window boundaries.
- Transfer with FRAME_LAST at edge m: ADDR_VALID=0 and DONE=1 in cycle m+1; IDLE in cycle m+2.
- START high during the DONE cycle is ignored. START held high into IDLE starts a new frame.

## Configuration
- CONV_AGEN_PAD_EN defined: "same" zero-padding.
  - P=(K-1)/2.
  - OUT_W = (IMG_W+2P-K)/STRIDE+1; OUT_H likewise.
  - row/col are offset by -P using signed arithmetic.
  - Out-of-range taps drive PAD=1 and ADDR=0, and still occupy a handshake slot.
- CONV_AGEN_PAD_EN undefined: no padding and no PAD port. Behaviour is exactly as in Operation.

## Structure
- Shared package conv_pkg holds:
  - the FSM state enum (IDLE, RUN, FIN);
  - a clog2 helper function;
  - OUT_W/OUT_H derivation functions, reused by the MAC and result-buffer blocks.
- One sub-module, conv_wrap_counter: parametrised MAX, with inputs clr and inc, outputs value and wrap (value==MAX & inc). It is instantiated four times to form the cascade.

## Test plan
- Default parameters, START, ADDR_READY=1:
  - window 0 addresses 0,1,2,4,5,6,8,9,10, with WIN_FIRST on 0 and WIN_LAST on 10;
  - window 1 addresses 1,2,3,5,6,7,9,10,11;
  - 36 transfers total, FRAME_LAST on address 15, DONE one cycle later.
- Backpressure: ADDR_READY low for 3 cycles while TAP=4 of window 0 → ADDR holds 5, TAP holds 4; the sequence resumes at 6 with no skip or duplicate.
- IMG_W=IMG_H=6, K=3, STRIDE=2 → 4 windows with tap-0 addresses 0, 2, 12, 14; 36 transfers.
- RESET asserted at transfer 20 → ADDR_VALID and BUSY fall without waiting for a clock; no DONE pulse; a new START gives address 0, TAP 0.
- START pulsed during RUN → no effect on the sequence. START held high through DONE → second frame begins from IDLE.
- CONV_AGEN_PAD_EN, default parameters:
  - 16 windows, 144 transfers;
  - window 0: taps 0,1,2,3,6 have PAD=1 and ADDR=0; taps 4,5,7,8 give addresses 0,1,4,5.
